// File: rtl/eth_vlg_pkg.sv
// Shared definitions for the eth_vlg TCP transmit path.
//   feeder_fsm_t        : burst FSM states of tcp_stream_feeder
//   TCP_*_DEF           : default sizing for tcp_stream_feeder
//   feeder_min          : unsigned minimum helper
package eth_vlg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } feeder_fsm_t;

  localparam int unsigned TCP_FIFO_DEPTH_DEF = 2048;
  localparam int unsigned TCP_BURST_LEN_DEF  = 1400;
  localparam int unsigned TCP_IDLE_TICKS_DEF = 10000;

  function automatic int unsigned feeder_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Single-clock byte FIFO with a registered read port.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   clear_i       : synchronous flush (pointers, fill and read register to 0)
//   wr_en_i       : push wr_data_i (caller guarantees not full)
//   rd_en_i       : pop; the popped byte appears on rd_data_o after the edge
//   fill_o        : occupancy, 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
module feeder_fifo #(
  parameter int unsigned DEPTH = 2048
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     rd_en_i,
  output logic [7:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [7:0]    rd_data_q, rd_data_d;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    fill_d    = fill_q;
    rd_data_d = rd_data_q;
    if (clear_i) begin
      wptr_d    = '0;
      rptr_d    = '0;
      fill_d    = '0;
      rd_data_d = '0;
    end else begin
      if (wr_en_i) wptr_d = wptr_q + 1'b1;
      if (rd_en_i) begin
        rptr_d    = rptr_q + 1'b1;
        rd_data_d = mem_q[rptr_q];
      end
      case ({wr_en_i, rd_en_i})
        2'b10:   fill_d = fill_q + 1'b1;
        2'b01:   fill_d = fill_q - 1'b1;
        default: fill_d = fill_q;
      endcase
    end
  end

  // RAM array has no reset so it can map onto block memory.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clear_i) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      fill_q    <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fill_q    <= fill_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign fill_o    = fill_q;

endmodule

// File: rtl/tcp_stream_feeder.sv
// Buffers user bytes and releases them to eth_vlg's TCP transmit input in
// contiguous bursts of at most BURST_LEN bytes, started only while tcp_cts is
// high. A partial burst is flushed after IDLE_TICKS idle cycles.
//   clk, rst        : clock, asynchronous active-high reset
//   in_d/in_v/in_rdy: user byte stream (accepted on in_v && in_rdy)
//   connected       : TCP session up; low flushes the FIFO and aborts bursts
//   tcp_cts         : clear-to-send, sampled only when a burst starts
//   tcp_din/tcp_vin : registered byte stream to eth_vlg
//   fill            : FIFO occupancy
// Optional macro TCP_FEEDER_STATS_EN adds bytes_sent[31:0] / bursts_sent[15:0].
module tcp_stream_feeder
  import eth_vlg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = TCP_FIFO_DEPTH_DEF,
  parameter int unsigned BURST_LEN  = TCP_BURST_LEN_DEF,
  parameter int unsigned IDLE_TICKS = TCP_IDLE_TICKS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_d,
  input  logic                          in_v,
  output logic                          in_rdy,
  input  logic                          connected,
  input  logic                          tcp_cts,
  output logic [7:0]                    tcp_din,
  output logic                          tcp_vin,
  output logic [$clog2(FIFO_DEPTH):0]   fill
`ifdef TCP_FEEDER_STATS_EN
  ,
  output logic [31:0]                   bytes_sent,
  output logic [15:0]                   bursts_sent
`endif
);

  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam int unsigned IW = $clog2(IDLE_TICKS + 1);

  localparam logic [FW-1:0] FULL_F      = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0] BURST_LEN_F = FW'(BURST_LEN);
  localparam logic [BW-1:0] BURST_LEN_B = BW'(BURST_LEN);
  localparam logic [IW-1:0] IDLE_MAX    = IW'(IDLE_TICKS);

  feeder_fsm_t   state_q, state_d;
  logic [BW-1:0] blen_q, blen_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          vin_q, vin_d;

  logic [FW-1:0] fill_w;
  logic          wr_en;
  logic          pop;
  logic          start_ok;
  logic          burst_start;

  assign in_rdy = connected && (fill_w != FULL_F);
  assign wr_en  = in_v && in_rdy;
  // Gating with connected stops the pop in the same cycle the link drops.
  assign pop    = (state_q == BURST) && connected;

  assign start_ok = tcp_cts && connected &&
                    ((fill_w >= BURST_LEN_F) ||
                     ((fill_w != '0) && (idle_q == IDLE_MAX)));

  feeder_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (!connected),
    .wr_en_i   (wr_en),
    .wr_data_i (in_d),
    .rd_en_i   (pop),
    .rd_data_o (tcp_din),
    .fill_o    (fill_w)
  );

  always_comb begin
    state_d     = state_q;
    blen_d      = blen_q;
    bcnt_d      = bcnt_q;
    burst_start = 1'b0;
    if (!connected) begin
      state_d = IDLE;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_d     = BURST;
            blen_d      = (fill_w < BURST_LEN_F) ? BW'(fill_w) : BURST_LEN_B;
            bcnt_d      = '0;
            burst_start = 1'b1;
          end
        end
        BURST: begin
          if (bcnt_q == blen_q - 1'b1) state_d = GAP;
          else                         bcnt_d  = bcnt_q + 1'b1;
        end
        GAP:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Idle counter keeps its value outside IDLE so a backlog left after a burst
  // is timed from the last write, not from the end of the burst.
  always_comb begin
    idle_d = idle_q;
    if (!connected || wr_en || (fill_w == '0)) begin
      idle_d = '0;
    end else if ((state_q == IDLE) && (idle_q != IDLE_MAX)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  assign vin_d = pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      blen_q  <= '0;
      bcnt_q  <= '0;
      idle_q  <= '0;
      vin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blen_q  <= blen_d;
      bcnt_q  <= bcnt_d;
      idle_q  <= idle_d;
      vin_q   <= vin_d;
    end
  end

  assign tcp_vin = vin_q;
  assign fill    = fill_w;

`ifdef TCP_FEEDER_STATS_EN
  logic [31:0] bytes_q;
  logic [15:0] bursts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bytes_q  <= '0;
      bursts_q <= '0;
    end else begin
      if (vin_q)       bytes_q  <= bytes_q + 32'd1;
      if (burst_start) bursts_q <= bursts_q + 16'd1;
    end
  end

  assign bytes_sent  = bytes_q;
  assign bursts_sent = bursts_q;
`else
  // burst_start only feeds the statistics counters.
  logic unused_burst_start;
  assign unused_burst_start = burst_start;
`endif

endmodule

// File: tb/tb_tcp_stream_feeder.sv
module tb_tcp_stream_feeder;

  localparam int unsigned DEPTH = 2048;
  localparam int unsigned BLEN  = 1400;
  localparam int unsigned IDLE  = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_d;
  logic        in_v;
  logic        in_rdy;
  logic        connected;
  logic        tcp_cts;
  logic [7:0]  tcp_din;
  logic        tcp_vin;
  logic [11:0] fill;
`ifdef TCP_FEEDER_STATS_EN
  logic [31:0] bytes_sent;
  logic [15:0] bursts_sent;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr_cyc = 0;

  // monitor state
  logic [7:0] rx_q[$];
  int         burst_len_q[$];
  int         start_q[$];
  int         end_q[$];
  bit         in_burst = 0;
  int         cur_len = 0;
  int         last_vin_cyc = 0;

  tcp_stream_feeder #(
    .FIFO_DEPTH (DEPTH),
    .BURST_LEN  (BLEN),
    .IDLE_TICKS (IDLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_d        (in_d),
    .in_v        (in_v),
    .in_rdy      (in_rdy),
    .connected   (connected),
    .tcp_cts     (tcp_cts),
    .tcp_din     (tcp_din),
    .tcp_vin     (tcp_vin),
    .fill        (fill)
`ifdef TCP_FEEDER_STATS_EN
    ,
    .bytes_sent  (bytes_sent),
    .bursts_sent (bursts_sent)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tcp_vin && !rst) begin
      if (!in_burst) begin
        in_burst = 1;
        cur_len  = 0;
        start_q.push_back(cyc);
      end
      rx_q.push_back(tcp_din);
      cur_len++;
      last_vin_cyc = cyc;
    end else if (in_burst) begin
      in_burst = 0;
      burst_len_q.push_back(cur_len);
      end_q.push_back(last_vin_cyc);
    end
  end

  function automatic logic [7:0] gen_byte(input int kind, input int i);
    case (kind)
      0:       return 8'(i % 256);
      1:       return 8'(8'hA0 + i);
      2:       return 8'((i * 7 + 3) % 256);
      default: return 8'(255 - (i % 256));
    endcase
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    burst_len_q.delete();
    start_q.delete();
    end_q.delete();
  endtask

  // Pushes n bytes of pattern kind, one per cycle when in_rdy allows.
  task automatic write_seq(input int kind, input int n);
    @(posedge clk); #1;
    in_v = 1'b1;
    for (int i = 0; i < n; i++) begin
      int tries;
      tries = 0;
      in_d = gen_byte(kind, i);
      while (!in_rdy && tries < 20000) begin
        @(posedge clk); #1;
        tries++;
      end
      @(posedge clk); #1;
      last_wr_cyc = cyc;
    end
    in_v = 1'b0;
  endtask

  task automatic wait_bursts(input int nb, input int budget, output bit ok);
    int n;
    n = 0;
    while (!(burst_len_q.size() >= nb && !in_burst) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    ok = (burst_len_q.size() >= nb && !in_burst);
  endtask

  task automatic test_reset();
    rst = 1'b1; connected = 1'b0; tcp_cts = 1'b0; in_v = 1'b0; in_d = 8'h00;
    #1;
    checks++; if (tcp_vin !== 1'b0) begin failures++; $display("FAIL reset_vin: got %b expected 0", tcp_vin); end
    checks++; if (tcp_din !== 8'h00) begin failures++; $display("FAIL reset_din: got %h expected 00", tcp_din); end
    checks++; if (fill !== 12'd0) begin failures++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy_disc: got %b expected 0", in_rdy); end
    connected = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy_conn: got %b expected 1", in_rdy); end
`ifdef TCP_FEEDER_STATS_EN
    checks++; if (bytes_sent !== 32'd0 || bursts_sent !== 16'd0) begin failures++;
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", bytes_sent, bursts_sent); end
`endif
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_full_burst();
    bit ok;
    int errs, first;
    clear_mon();
    tcp_cts = 1'b1;
    write_seq(0, 1400);
    wait_bursts(1, 3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout: got %0d bursts expected 1", burst_len_q.size()); end
    checks++; if (burst_len_q.size() != 1 || burst_len_q[0] != 1400) begin failures++;
      $display("FAIL full_len: got %0d bursts first %0d expected 1 of 1400", burst_len_q.size(),
               burst_len_q.size() > 0 ? burst_len_q[0] : -1); end
    // last write edge w -> BURST at w+1 -> first tcp_vin after w+2
    checks++; if (start_q.size() == 0 || start_q[0] - last_wr_cyc != 2) begin failures++;
      $display("FAIL full_latency: got %0d expected 2", start_q.size() > 0 ? start_q[0] - last_wr_cyc : -1); end
    errs = 0; first = -1;
    for (int i = 0; i < 1400; i++)
      if (i >= rx_q.size() || rx_q[i] !== gen_byte(0, i)) begin errs++; if (first < 0) first = i; end
    checks++; if (errs != 0) begin failures++; $display("FAIL full_data: got %0d bad bytes (first at %0d) expected 0", errs, first); end
    checks++; if (fill !== 12'd0) begin failures++; $display("FAIL full_fill: got %0d expected 0", fill); end
  endtask

  task automatic test_partial_flush();
    bit ok;
    int errs;
    clear_mon();
    tcp_cts = 1'b1;
    write_seq(1, 10);
    wait_bursts(1, IDLE + 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL partial_timeout: got %0d bursts expected 1", burst_len_q.size()); end
    checks++; if (burst_len_q.size() != 1 || burst_len_q[0] != 10) begin failures++;
      $display("FAIL partial_len: got %0d expected 10", burst_len_q.size() > 0 ? burst_len_q[0] : -1); end
    // idle counter hits IDLE at edge w+IDLE, BURST at w+IDLE+1, data after w+IDLE+2
    checks++; if (start_q.size() == 0 || start_q[0] - last_wr_cyc != IDLE + 2) begin failures++;
      $display("FAIL partial_delay: got %0d expected %0d", start_q.size() > 0 ? start_q[0] - last_wr_cyc : -1, IDLE + 2); end
    errs = 0;
    for (int i = 0; i < 10; i++)
      if (i >= rx_q.size() || rx_q[i] !== gen_byte(1, i)) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL partial_data: got %0d bad bytes expected 0", errs); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int errs, gap_bad;
    clear_mon();
    tcp_cts = 1'b1;
    write_seq(2, 3000);
    wait_bursts(3, IDLE + 4000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: got %0d bursts expected 3", burst_len_q.size()); end
    checks++; if (burst_len_q.size() != 3) begin failures++; $display("FAIL b2b_count: got %0d expected 3", burst_len_q.size()); end
    checks++; if (burst_len_q.size() < 1 || burst_len_q[0] != 1400) begin failures++;
      $display("FAIL b2b_len0: got %0d expected 1400", burst_len_q.size() > 0 ? burst_len_q[0] : -1); end
    checks++; if (burst_len_q.size() < 2 || burst_len_q[1] != 1400) begin failures++;
      $display("FAIL b2b_len1: got %0d expected 1400", burst_len_q.size() > 1 ? burst_len_q[1] : -1); end
    checks++; if (burst_len_q.size() < 3 || burst_len_q[2] != 200) begin failures++;
      $display("FAIL b2b_len2: got %0d expected 200", burst_len_q.size() > 2 ? burst_len_q[2] : -1); end
    gap_bad = 0;
    for (int b = 1; b < start_q.size() && b < end_q.size() + 1; b++)
      if (start_q[b] - end_q[b-1] < 2) gap_bad++;
    checks++; if (gap_bad != 0) begin failures++; $display("FAIL b2b_gap: got %0d bubble-free joins expected 0", gap_bad); end
    errs = 0;
    for (int i = 0; i < 3000; i++)
      if (i >= rx_q.size() || rx_q[i] !== gen_byte(2, i)) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL b2b_data: got %0d bad bytes expected 0", errs); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int errs, n;
    clear_mon();
    tcp_cts = 1'b0;
    write_seq(3, 2048);
    checks++; if (fill !== 12'd2048) begin failures++; $display("FAIL bp_fill_full: got %0d expected 2048", fill); end
    in_v = 1'b1; in_d = 8'h5A;
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL bp_rdy_low: got %b expected 0", in_rdy); end
    checks++; if (fill !== 12'd2048) begin failures++; $display("FAIL bp_fill_hold: got %0d expected 2048", fill); end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL bp_no_output: got %0d bytes expected 0", rx_q.size()); end
    in_v = 1'b0;
    tcp_cts = 1'b1;
    n = 0;
    while (!in_burst && n < 20) begin @(negedge clk); #1; n++; end
    tcp_cts = 1'b0;   // deassert during the burst must not cut it short
    wait_bursts(1, 2000, ok);
    checks++; if (!ok || burst_len_q[0] != 1400) begin failures++;
      $display("FAIL bp_burst_len: got %0d expected 1400", burst_len_q.size() > 0 ? burst_len_q[0] : -1); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy_back: got %b expected 1", in_rdy); end
    checks++; if (fill !== 12'd648) begin failures++; $display("FAIL bp_fill_left: got %0d expected 648", fill); end
    errs = 0;
    for (int i = 0; i < 1400; i++)
      if (i >= rx_q.size() || rx_q[i] !== gen_byte(3, i)) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL bp_data: got %0d bad bytes expected 0", errs); end
    connected = 1'b0;
    @(negedge clk); #1;
    checks++; if (fill !== 12'd0) begin failures++; $display("FAIL bp_clear: got %0d expected 0", fill); end
    connected = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_connected_drop();
    int n, errs;
    clear_mon();
    tcp_cts = 1'b1;
    write_seq(0, 1400);
    n = 0;
    while (!(in_burst && cur_len >= 500) && n < 3000) begin @(negedge clk); #1; n++; end
    checks++; if (cur_len != 500) begin failures++; $display("FAIL drop_reach: got %0d bytes expected 500", cur_len); end
    connected = 1'b0;
    @(negedge clk); #1;
    checks++; if (tcp_vin !== 1'b0) begin failures++; $display("FAIL drop_vin: got %b expected 0", tcp_vin); end
    checks++; if (fill !== 12'd0) begin failures++; $display("FAIL drop_fill: got %0d expected 0", fill); end
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL drop_rdy: got %b expected 0", in_rdy); end
    checks++; if (burst_len_q.size() != 1 || burst_len_q[0] != 500) begin failures++;
      $display("FAIL drop_len: got %0d expected 500", burst_len_q.size() > 0 ? burst_len_q[0] : -1); end
    errs = 0;
    for (int i = 0; i < 500; i++)
      if (i >= rx_q.size() || rx_q[i] !== gen_byte(0, i)) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL drop_data: got %0d bad bytes expected 0", errs); end
    repeat (3) @(posedge clk);
    connected = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_async_reset();
    int n;
    clear_mon();
`ifdef TCP_FEEDER_STATS_EN
    // 1400 + 10 + 3000 + 1400 + 500 bytes over 1 + 1 + 3 + 1 + 1 bursts
    checks++; if (bytes_sent !== 32'd6310) begin failures++; $display("FAIL stats_bytes: got %0d expected 6310", bytes_sent); end
    checks++; if (bursts_sent !== 16'd7) begin failures++; $display("FAIL stats_bursts: got %0d expected 7", bursts_sent); end
`endif
    tcp_cts = 1'b1;
    write_seq(2, 1400);
    n = 0;
    while (!(in_burst && cur_len >= 100) && n < 3000) begin @(negedge clk); #1; n++; end
    checks++; if (!in_burst) begin failures++; $display("FAIL rst_burst_seen: got %b expected 1", in_burst); end
    #1 rst = 1'b1;
    #1;
    checks++; if (tcp_vin !== 1'b0) begin failures++; $display("FAIL rst_vin: got %b expected 0", tcp_vin); end
    checks++; if (tcp_din !== 8'h00) begin failures++; $display("FAIL rst_din: got %h expected 00", tcp_din); end
    checks++; if (fill !== 12'd0) begin failures++; $display("FAIL rst_fill: got %0d expected 0", fill); end
`ifdef TCP_FEEDER_STATS_EN
    checks++; if (bytes_sent !== 32'd0 || bursts_sent !== 16'd0) begin failures++;
      $display("FAIL rst_stats: got %0d/%0d expected 0/0", bytes_sent, bursts_sent); end
`endif
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_burst();
    test_partial_flush();
    test_back_to_back();
    test_backpressure();
    test_connected_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
